// File: rtl/score_uart_tx.sv
// UART transmitter for the multiplayer score byte: sends on change and as a periodic keepalive.
// Define SCORE_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module score_uart_tx #(
  parameter int CLK_HZ         = 65_000_000,
  parameter int BAUD           = 115_200,
  parameter int CLKS_PER_BIT   = CLK_HZ / BAUD,
  parameter int REFRESH_CYCLES = 6_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_to_transmit,
  output logic        tx,
  output logic        tx_busy,
  output logic [15:0] frame_cnt
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

`ifdef SCORE_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t             state_r, state_s;
  logic [BAUD_W-1:0]  baud_r, baud_s;
  logic [2:0]         bit_r, bit_s;
  logic [7:0]         shift_r, shift_s;
  logic [7:0]         last_r, last_s;
  logic [REF_W-1:0]   refresh_r, refresh_s;
  logic [15:0]        frame_s;
  logic               tx_s;
  logic               busy_s;
  logic               baud_last_s;

  // Next-state, datapath and registered-output values
  always_comb begin
    state_s     = state_r;
    baud_s      = baud_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    last_s      = last_r;
    refresh_s   = refresh_r;
    frame_s     = frame_cnt;
    baud_last_s = (baud_r == BAUD_LAST);

    case (state_r)
      IDLE: begin
        // A change and an expiring refresh on the same cycle still yield a single frame
        if ((data_to_transmit != last_r) || (refresh_r == REF_LAST)) begin
          state_s   = START;
          shift_s   = data_to_transmit;
          last_s    = data_to_transmit;
          refresh_s = {REF_W{1'b0}};
          baud_s    = {BAUD_W{1'b0}};
        end else begin
          refresh_s = refresh_r + REF_W'(1);
        end
      end
      START: begin
        if (baud_last_s) begin
          state_s = DATA;
          baud_s  = {BAUD_W{1'b0}};
          bit_s   = 3'd0;
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_s = {BAUD_W{1'b0}};
          if (bit_r == 3'd7) begin
`ifdef SCORE_UART_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
`ifdef SCORE_UART_PARITY_EN
      PARITY: begin
        if (baud_last_s) begin
          state_s = STOP;
          baud_s  = {BAUD_W{1'b0}};
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_last_s) begin
          state_s   = IDLE;
          baud_s    = {BAUD_W{1'b0}};
          frame_s   = frame_cnt + 16'd1;
          refresh_s = {REF_W{1'b0}};
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = {BAUD_W{1'b0}};
      end
    endcase

    // Line level is derived from the upcoming state so tx itself can be a flop
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[bit_s];
`ifdef SCORE_UART_PARITY_EN
      PARITY:  tx_s = ^shift_s;
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      baud_r    <= {BAUD_W{1'b0}};
      bit_r     <= 3'd0;
      shift_r   <= 8'h00;
      last_r    <= 8'h00;
      refresh_r <= {REF_W{1'b0}};
      frame_cnt <= 16'd0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      last_r    <= last_s;
      refresh_r <= refresh_s;
      frame_cnt <= frame_s;
      tx        <= tx_s;
      tx_busy   <= busy_s;
    end
  end

endmodule

// File: tb/tb_score_uart_tx.sv
// Bench for score_uart_tx: directed and random byte changes checked against a line-waveform model.
module tb_score_uart_tx;

  localparam int CPB = 4;
  localparam int REF = 200;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_to_transmit;
  logic        tx;
  logic        tx_busy;
  logic [15:0] frame_cnt;

  int vectors;
  int errors;

  // Reference model: the expected line level for every future cycle of a frame
  logic        q[$];
  logic        in_frame;
  logic [7:0]  m_last;
  int          m_idle;
  logic [15:0] m_cnt;
  logic        m_tx;
  logic        m_busy;

  score_uart_tx #(
    .CLK_HZ(1000),
    .BAUD(250),
    .CLKS_PER_BIT(CPB),
    .REFRESH_CYCLES(REF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_to_transmit(data_to_transmit),
    .tx(tx),
    .tx_busy(tx_busy),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_bits(input logic level);
    for (int k = 0; k < CPB; k++) q.push_back(level);
  endtask

  task automatic build_frame(input logic [7:0] d);
    push_bits(1'b0);
    for (int b = 0; b < 8; b++) push_bits(d[b]);
`ifdef SCORE_UART_PARITY_EN
    push_bits(^d);
`endif
    push_bits(1'b1);
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled
  task automatic model_step();
    if (!rst_n) begin
      q.delete();
      in_frame = 1'b0;
      m_last   = 8'h00;
      m_idle   = 0;
      m_cnt    = 16'd0;
      m_tx     = 1'b1;
      m_busy   = 1'b0;
    end else if (q.size() > 0) begin
      m_tx   = q.pop_front();
      m_busy = 1'b1;
    end else if (in_frame) begin
      in_frame = 1'b0;
      m_cnt    = m_cnt + 16'd1;
      m_idle   = 0;
      m_tx     = 1'b1;
      m_busy   = 1'b0;
    end else if ((data_to_transmit != m_last) || (m_idle == REF - 1)) begin
      build_frame(data_to_transmit);
      m_last   = data_to_transmit;
      m_idle   = 0;
      in_frame = 1'b1;
      m_tx     = q.pop_front();
      m_busy   = 1'b1;
    end else begin
      if (m_idle < REF - 1) m_idle++;
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("tx", {15'd0, tx}, {15'd0, m_tx});
      chk("tx_busy", {15'd0, tx_busy}, {15'd0, m_busy});
      chk("frame_cnt", frame_cnt, m_cnt);
    end
  endtask

  initial begin
    int guard;
    vectors  = 0;
    errors   = 0;
    in_frame = 1'b0;
    m_last   = 8'h00;
    m_idle   = 0;
    m_cnt    = 16'd0;
    m_tx     = 1'b1;
    m_busy   = 1'b0;
    rst_n            = 1'b0;
    data_to_transmit = 8'h00;
    tick(3);
    rst_n = 1'b1;

    // Quiet line after reset, then a keepalive carrying 0x00
    tick(150);
    chk("quiet_after_reset_cnt", frame_cnt, 16'd0);
    tick(110);
    chk("keepalive_cnt", frame_cnt, 16'd1);

    // Change to 0x17: frame starts the edge after the change
    data_to_transmit = 8'h17;
    tick(1);
    chk("start_latency_tx", {15'd0, tx}, 16'd0);
    tick(59);

    // Several changes during one frame collapse into one back-to-back frame
    data_to_transmit = 8'h2A;
    tick(10);
    data_to_transmit = 8'h27;
    tick(5);
    data_to_transmit = 8'h2F;
    tick(120);

    // Constant data: keepalives only
    tick(600);

    // Change and refresh expiry on the same cycle
    guard = 0;
    while ((in_frame || q.size() > 0 || m_idle != REF - 1) && guard < 1000) begin
      tick(1);
      guard++;
    end
    chk("refresh_align_timeout", {15'd0, guard >= 1000}, 16'd0);
    data_to_transmit = 8'h3C;
    tick(120);

    // Reset during DATA bit 3, then a fresh frame
    data_to_transmit = 8'h5A;
    tick(18);
    rst_n = 1'b0;
    tick(1);
    chk("reset_abort_tx", {15'd0, tx}, 16'd1);
    chk("reset_abort_cnt", frame_cnt, 16'd0);
    rst_n = 1'b1;
    data_to_transmit = 8'hC3;
    tick(60);

    // Random changes at random spacing, including mid-frame
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) != 0) data_to_transmit = 8'($urandom);
      tick($urandom_range(1, 60));
    end
    tick(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
